prime_fifo_writer: RTL and testbench

Producer side of the prime candidate FIFO that feeds the RSA prime selector. Accepts candidate words and primality verdicts from the primality-test engine over a valid/ready handshake. Rejects composites, trivial values and recent duplicates, then writes surviving primes into the FIFO one word per write. Keeps saturating statistics counters for the host.

---
 rtl/prime_fifo_writer.sv | 155 +++++++++++++++
 tb/tb_prime_fifo_writer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_fifo_writer.sv
// prime_fifo_writer
//
// Producer side of the prime candidate FIFO feeding the RSA prime selector.
// Takes candidate words plus primality verdicts from the primality-test
// engine over a valid/ready handshake. It drops composites, trivial values
// and recent duplicates, and writes the surviving primes into the FIFO one
// word per write strobe. It also keeps saturating statistics counters.
//
// Ports:
//   aclk, aresetn   clock, synchronous active-low reset
//   enable          high = accept new candidates; low = finish current, then stop
//   cand_valid      candidate word and verdict are valid
//   cand_ready      writer accepts a candidate this cycle (registered)
//   cand_data       candidate value, unsigned, WIDTH bits
//   cand_is_prime   primality verdict, qualified by cand_valid
//   fifo_full       FIFO programmable-full flag (needs >= 1 entry of margin)
//   fifo_wr_en      FIFO write strobe, one cycle per accepted prime
//   fifo_din        FIFO write data, holds the last written word
//   prime_count     primes written since reset, saturating
//   drop_count      candidates rejected since reset, saturating
module prime_fifo_writer #(
    parameter int WIDTH = 512,
    parameter int HIST  = 4,
    parameter int CNT_W = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             enable,
    input  logic             cand_valid,
    output logic             cand_ready,
    input  logic [WIDTH-1:0] cand_data,
    input  logic             cand_is_prime,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [WIDTH-1:0] fifo_din,
    output logic [CNT_W-1:0] prime_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] CHECK     = 2'd1;
    localparam logic [1:0] WAIT_FULL = 2'd2;
    localparam logic [1:0] WRITE     = 2'd3;

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] cand_reg;
    logic             prime_reg;
    logic             cand_ready_reg;
    logic             fifo_wr_en_reg;
    logic [WIDTH-1:0] fifo_din_reg;
    logic [CNT_W-1:0] prime_count_reg;
    logic [CNT_W-1:0] drop_count_reg;

    logic [WIDTH-1:0] hist_data_reg [HIST];
    logic [HIST-1:0]  hist_valid_reg;
    logic [HIST-1:0]  hist_hit;

    logic take;
    logic drop;
    logic enter_write;

    // A transfer is only possible in IDLE; cand_ready_reg is already
    // qualified by the state, the state check just makes that explicit.
    assign take        = (state_reg == IDLE) && cand_valid && cand_ready_reg;
    assign enter_write = (state_next == WRITE);

    // Full-width equality against every valid history slot.
    generate
        for (genvar gi = 0; gi < HIST; gi++) begin : g_hit
            assign hist_hit[gi] = hist_valid_reg[gi] && (hist_data_reg[gi] == cand_reg);
        end
    endgenerate

    // Zero, one, even numbers other than 2, engine composites and recent
    // duplicates are all rejected.
    assign drop = !prime_reg
               || (cand_reg < WIDTH'(2))
               || (!cand_reg[0] && (cand_reg != WIDTH'(2)))
               || (|hist_hit);

    always_comb begin
        state_next = IDLE;
        case (state_reg)
            IDLE:      state_next = take ? CHECK : IDLE;
            CHECK:     state_next = drop ? IDLE : (fifo_full ? WAIT_FULL : WRITE);
            WAIT_FULL: state_next = fifo_full ? WAIT_FULL : WRITE;
            WRITE:     state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Outputs are computed from state_next so that they line up with the
    // state they describe: the write strobe is high during the WRITE cycle.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg       <= IDLE;
            cand_reg        <= '0;
            prime_reg       <= 1'b0;
            cand_ready_reg  <= 1'b0;
            fifo_wr_en_reg  <= 1'b0;
            fifo_din_reg    <= '0;
            prime_count_reg <= '0;
            drop_count_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            cand_ready_reg <= (state_next == IDLE) && enable;
            fifo_wr_en_reg <= enter_write;

            if (take) begin
                cand_reg  <= cand_data;
                prime_reg <= cand_is_prime;
            end

            if (enter_write) begin
                fifo_din_reg <= cand_reg;
                if (prime_count_reg != '1) begin
                    prime_count_reg <= prime_count_reg + 1'b1;
                end
            end

            if ((state_reg == CHECK) && drop && (drop_count_reg != '1)) begin
                drop_count_reg <= drop_count_reg + 1'b1;
            end
        end
    end

    // History shift register: slot 0 takes the new prime, the oldest entry
    // falls off the end. It shifts on entry to WRITE, so the next
    // candidate's CHECK already sees it.
    generate
        for (genvar gi = 0; gi < HIST; gi++) begin : g_hist
            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    hist_data_reg[gi]  <= '0;
                    hist_valid_reg[gi] <= 1'b0;
                end else if (enter_write) begin
                    if (gi == 0) begin
                        hist_data_reg[gi]  <= cand_reg;
                        hist_valid_reg[gi] <= 1'b1;
                    end else begin
                        hist_data_reg[gi]  <= hist_data_reg[(gi == 0) ? 0 : gi - 1];
                        hist_valid_reg[gi] <= hist_valid_reg[(gi == 0) ? 0 : gi - 1];
                    end
                end
            end
        end
    endgenerate

    assign cand_ready  = cand_ready_reg;
    assign fifo_wr_en  = fifo_wr_en_reg;
    assign fifo_din    = fifo_din_reg;
    assign prime_count = prime_count_reg;
    assign drop_count  = drop_count_reg;

endmodule

// File: tb/tb_prime_fifo_writer.sv
// Testbench for prime_fifo_writer: directed steps followed by random
// candidates, checked against a queue-based reference model of the writer.
module tb_prime_fifo_writer;

    localparam int WIDTH = 16;
    localparam int HIST  = 4;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             aclk = 1'b0;
    logic             aresetn;
    logic             enable;
    logic             cand_valid;
    logic             cand_ready;
    logic [WIDTH-1:0] cand_data;
    logic             cand_is_prime;
    logic             fifo_full;
    logic             fifo_wr_en;
    logic [WIDTH-1:0] fifo_din;
    logic [CNT_W-1:0] prime_count;
    logic [CNT_W-1:0] drop_count;

    prime_fifo_writer #(.WIDTH(WIDTH), .HIST(HIST), .CNT_W(CNT_W)) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .cand_valid(cand_valid), .cand_ready(cand_ready),
        .cand_data(cand_data), .cand_is_prime(cand_is_prime),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .prime_count(prime_count), .drop_count(drop_count)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] hist_q [$];
    int               exp_pcnt = 0;
    int               exp_dcnt = 0;

    // Observed writes, captured on the falling edge
    logic [WIDTH-1:0] obs_q [$];
    logic             prev_wr = 1'b0;
    int               pulse_err = 0;

    always @(negedge aclk) begin
        if (fifo_wr_en === 1'b1) obs_q.push_back(fifo_din);
        if (fifo_wr_en === 1'b1 && prev_wr === 1'b1) pulse_err++;
        prev_wr = fifo_wr_en;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Reference model: the writer's acceptance rules applied to one candidate.
    task automatic model(input logic [WIDTH-1:0] v, input logic p);
        bit dropped;
        dropped = !p || (v < 2) || ((v % 2 == 0) && (v != 2));
        foreach (hist_q[i]) if (hist_q[i] == v) dropped = 1;
        if (dropped) begin
            if (exp_dcnt < CMAX) exp_dcnt++;
        end else begin
            exp_q.push_back(v);
            hist_q.push_front(v);
            if (hist_q.size() > HIST) void'(hist_q.pop_back());
            if (exp_pcnt < CMAX) exp_pcnt++;
        end
        $display("txn cand=%0d prime=%0d -> %s", v, p, dropped ? "drop" : "write");
    endtask

    task automatic model_reset();
        hist_q.delete();
        exp_pcnt = 0;
        exp_dcnt = 0;
    endtask

    // Holds cand_valid until a transfer happens or the bound expires.
    task automatic xfer(input logic [WIDTH-1:0] v, input logic p, output bit ok);
        bit r;
        cand_data = v; cand_is_prime = p; cand_valid = 1'b1; ok = 0;
        for (int i = 0; i < 20; i++) begin
            r = cand_ready;
            tick();
            if (r) begin ok = 1; break; end
        end
        cand_valid = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_nwrites"}, obs_q.size(), exp_q.size());
        if (exp_q.size() > 0 && obs_q.size() > 0) chk({tag, "_din"}, obs_q[$], exp_q[$]);
        chk({tag, "_pcnt"}, prime_count, exp_pcnt);
        chk({tag, "_dcnt"}, drop_count, exp_dcnt);
    endtask

    task automatic txn(input string tag, input logic [WIDTH-1:0] v, input logic p);
        bit ok;
        xfer(v, p, ok);
        chk({tag, "_hs"}, ok, 1);
        model(v, p);
        repeat (3) tick();
        check_state(tag);
    endtask

    initial begin
        bit ok;
        bit seen;
        aresetn = 1'b0; enable = 1'b0; cand_valid = 1'b0;
        cand_data = '0; cand_is_prime = 1'b0; fifo_full = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_ready", cand_ready, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_din", fifo_din, 0);
        chk("rst_pcnt", prime_count, 0);
        chk("rst_dcnt", drop_count, 0);
        aresetn = 1'b1; enable = 1'b1;
        repeat (2) tick();

        // 1: latency of a single prime
        xfer(16'd13, 1'b1, ok);
        chk("t1_hs", ok, 1);
        model(16'd13, 1'b1);
        chk("t1_ready_drop", cand_ready, 0);
        chk("t1_wr_T1", fifo_wr_en, 0);
        tick();
        chk("t1_wr_T2", fifo_wr_en, 1);
        chk("t1_din_T2", fifo_din, 13);
        tick();
        chk("t1_wr_T3", fifo_wr_en, 0);
        chk("t1_din_hold", fifo_din, 13);
        tick();
        check_state("t1");

        // 2: trivial and composite rejects, 2 accepted
        txn("t2a", 16'd15, 1'b0);
        txn("t2b", 16'd8, 1'b1);
        txn("t2c", 16'd1, 1'b1);
        txn("t2d", 16'd2, 1'b1);

        // 3: duplicate window
        txn("t3a", 16'd17, 1'b1);
        txn("t3b", 16'd19, 1'b1);
        txn("t3c", 16'd23, 1'b1);
        txn("t3d", 16'd29, 1'b1);
        txn("t3dup", 16'd17, 1'b1);
        txn("t3e", 16'd31, 1'b1);
        txn("t3evict", 16'd17, 1'b1);

        // 4: FIFO full stall
        fifo_full = 1'b1;
        xfer(16'd37, 1'b1, ok);
        chk("t4_hs", ok, 1);
        model(16'd37, 1'b1);
        seen = 0;
        repeat (10) begin
            tick();
            if (fifo_wr_en !== 1'b0 || cand_ready !== 1'b0) seen = 1;
        end
        chk("t4_stall", seen, 0);
        chk("t4_nowrite", obs_q.size(), exp_q.size() - 1);
        fifo_full = 1'b0;
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (fifo_wr_en === 1'b1) begin
                seen = 1;
                chk("t4_din", fifo_din, 37);
                break;
            end
        end
        chk("t4_released", seen, 1);
        repeat (2) tick();
        check_state("t4");

        // 5: enable dropped while busy
        xfer(16'd41, 1'b1, ok);
        chk("t5_hs", ok, 1);
        model(16'd41, 1'b1);
        enable = 1'b0;
        cand_data = 16'd43; cand_is_prime = 1'b1; cand_valid = 1'b1;
        seen = 0;
        repeat (8) begin
            tick();
            if (cand_ready !== 1'b0) seen = 1;
        end
        chk("t5_ready_low", seen, 0);
        check_state("t5a");
        enable = 1'b1;
        txn("t5b", 16'd43, 1'b1);

        // 6: reset during WAIT_FULL
        fifo_full = 1'b1;
        xfer(16'd47, 1'b1, ok);
        chk("t6_hs", ok, 1);
        $display("txn cand=47 prime=1 -> discarded by reset");
        repeat (3) tick();
        aresetn = 1'b0;
        tick();
        model_reset();
        chk("t6_ready", cand_ready, 0);
        chk("t6_wr_en", fifo_wr_en, 0);
        chk("t6_din", fifo_din, 0);
        chk("t6_pcnt", prime_count, 0);
        chk("t6_dcnt", drop_count, 0);
        aresetn = 1'b1; fifo_full = 1'b0;
        repeat (5) tick();
        chk("t6_nowrite", obs_q.size(), exp_q.size());
        txn("t6_resend", 16'd13, 1'b1);

        // Random candidates: small range for duplicates, counters saturate
        for (int n = 0; n < 40; n++) begin
            logic [WIDTH-1:0] v;
            logic p;
            v = WIDTH'($urandom_range(0, 40));
            p = ($urandom_range(0, 3) != 0);
            txn("rnd", v, p);
        end

        chk("wr_pulse", pulse_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
